instr_fetch_stage: RTL
======================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000; instruction word loaded into IF/ID on reset and flush.
REQ-002 SHALL have parameter PC_INC, default 4; byte increment added to fetch address to form next-PC.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 pc_in  in  32  current fetch address from the PC register.
REQ-007 pc_en  out  1  combinational; PC register loads its next value at the coming edge.
REQ-008 imem_req  out  1  registered; instruction-memory read request.
REQ-009 imem_addr  out  32  registered; read address, stable while imem_req=1.
REQ-010 imem_ack  in  1  memory returns imem_rdata this cycle; any latency of 1 or more cycles.
REQ-011 imem_rdata  in  32  instruction word, valid only with imem_ack.
REQ-012 stall_in  in  1  decode cannot accept a new instruction.
REQ-013 flush_in  in  1  branch or jump taken; squash fetch-side state.
REQ-014 if_id_instr  out  32  IF/ID instruction register.
REQ-015 if_id_npc  out  32  IF/ID next-PC register (fetch address + PC_INC).
REQ-016 if_id_valid  out  1  IF/ID holds a live instruction.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, HOLD.
REQ-018 IDLE: SHALL capture pc_in into imem_addr, set imem_req=1, and go to WAIT, all at the same edge.
REQ-019 WAIT: SHALL hold imem_req=1 and imem_addr unchanged until imem_ack; a request is never aborted.
REQ-020 WAIT with imem_ack, kill=0, flush_in=0, and (if_id_valid=0 or stall_in=0): at the next edge, SHALL load if_id_instr=imem_rdata, if_id_npc=imem_addr+PC_INC (mod 2^32), and if_id_valid=1; clear imem_req; assert pc_en this cycle; go to IDLE.
REQ-021 WAIT with imem_ack while if_id_valid=1 and stall_in=1: SHALL store rdata and npc in a one-entry skid buffer, clear imem_req, and go to HOLD; pc_en stays 0.
REQ-022 HOLD: when stall_in=0, SHALL move the buffer into IF/ID with if_id_valid=1, assert pc_en, and go to IDLE.
REQ-023 flush_in in any state SHALL assert pc_en (so the PC register loads the branch target) and, at the next edge, set if_id_valid=0 and if_id_instr=NOP_INSTR.
REQ-024 flush_in in HOLD SHALL discard the buffer and go to IDLE.
REQ-025 flush_in in WAIT without imem_ack SHALL set a kill flag.
REQ-026 The returning ack with kill=1 SHALL be discarded, clear kill, go to IDLE, and not assert pc_en.
REQ-027 flush_in in WAIT with imem_ack SHALL discard the data and go to IDLE.
REQ-028 flush_in SHALL take priority over ack, stall_in, and buffer drain.
REQ-029 With no load and no flush: stall_in=1 SHALL hold all IF/ID registers; stall_in=0 SHALL clear if_id_valid (consumed) and leave instr/npc unchanged.
REQ-030 Throughput SHALL be one instruction per 2 cycles with a 1-cycle memory; fetch-to-valid latency SHALL be 1 IDLE cycle + memory latency + 1 edge.
REQ-031 An address of 32'hFFFF_FFFC SHALL wrap if_id_npc to 32'h0000_0000.

Reset
REQ-032 While rst=1, asynchronously: state=IDLE, imem_req=0, imem_addr=0, if_id_instr=NOP_INSTR, if_id_npc=0, if_id_valid=0, kill=0, buffer=0.
REQ-033 pc_en SHALL be 0 during reset.
REQ-034 Reset mid-WAIT SHALL drop the outstanding request without waiting for ack.
REQ-035 The first request SHALL issue from IDLE in the first cycle after rst falls.

Structure
REQ-036 A shared package mips32_pkg SHALL hold NOP_INSTR, PC_INC, and the fetch-state encoding; the decode and PC stages reuse them.
REQ-037 The IF/ID register (instr, npc, valid, with stall/flush/load controls) SHALL be sub-module if_id_reg; the FSM, skid buffer, and kill logic stay in instr_fetch_stage.

Verification
REQ-038 Reset release with pc_in=0, 1-cycle ack, rdata=32'h2001_0005 -> imem_req=1 with addr 0, then if_id_instr=32'h2001_0005, npc=4, valid=1, with a 1-cycle pc_en pulse.
REQ-039 Ack latency of 3 cycles at pc_in=32'h40 -> imem_addr stays 32'h40 for all 3 cycles; npc=32'h44; exactly one pc_en pulse.
REQ-040 stall_in=1 held for 4 cycles while if_id_valid=1 and the next ack arrives -> state=HOLD, IF/ID unchanged; stall drop -> buffered word appears next edge, with pc_en pulse.
REQ-041 flush_in in WAIT cycle 1 of a 3-cycle ack -> valid=0, instr=NOP_INSTR; returning data discarded; next request uses the updated pc_in (branch target 32'h100).
REQ-042 flush_in coincident with imem_ack and stall_in=1 -> data dropped, valid=0, state=IDLE, pc_en=1.
REQ-043 pc_in=32'hFFFF_FFFC -> if_id_npc=32'h0000_0000; rst asserted mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline constants and the fetch-stage state encoding.
package mips32_pkg;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INC_DEF    = 32'd4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StHold = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, next-PC and valid flag.
module if_id_reg
   import mips32_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic        stall_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] npc_i,
   output logic [31:0] instr_o,
   output logic [31:0] npc_o,
   output logic        valid_o
);

   // Flush beats load; without a load, decode either holds (stall) or consumes the entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_o <= NOP_INSTR;
         npc_o   <= 32'h0000_0000;
         valid_o <= 1'b0;
      end else if (flush_i) begin
         instr_o <= NOP_INSTR;
         valid_o <= 1'b0;
      end else if (load_i) begin
         instr_o <= instr_i;
         npc_o   <= npc_i;
         valid_o <= 1'b1;
      end else if (!stall_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: request FSM, one-entry skid buffer and flush-kill tracking.
module instr_fetch_stage
   import mips32_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter logic [31:0] PC_INC    = PC_INC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall_in,
   input  logic        flush_in,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_npc,
   output logic        if_id_valid
);

   fetch_state_e state_q;
   logic         imem_req_q;
   logic [31:0]  imem_addr_q;
   logic         kill_q;
   logic [31:0]  buf_instr_q;
   logic [31:0]  buf_npc_q;

   logic         ack_accept;
   logic         hold_drain;
   logic         load_en;
   logic [31:0]  load_instr;
   logic [31:0]  load_npc;
   logic [31:0]  fetch_npc;

   assign imem_req  = imem_req_q;
   assign imem_addr = imem_addr_q;
   assign fetch_npc = imem_addr_q + PC_INC;

   // Decide whether IF/ID loads this cycle and whether the PC register advances.
   always_comb begin
      ack_accept = (state_q == StWait) && imem_ack && !kill_q && !flush_in &&
                   (!if_id_valid || !stall_in);
      hold_drain = (state_q == StHold) && !flush_in && !stall_in;
      load_en    = ack_accept || hold_drain;
      load_instr = hold_drain ? buf_instr_q : imem_rdata;
      load_npc   = hold_drain ? buf_npc_q : fetch_npc;
      pc_en      = !rst && (flush_in || load_en);
   end

   // Fetch FSM with registered request, address, kill flag and skid buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         imem_req_q  <= 1'b0;
         imem_addr_q <= 32'h0000_0000;
         kill_q      <= 1'b0;
         buf_instr_q <= 32'h0000_0000;
         buf_npc_q   <= 32'h0000_0000;
      end else begin
         case (state_q)
            StIdle: begin
               // On a flush pc_in is still the old PC; wait one cycle for the branch target.
               if (!flush_in) begin
                  imem_req_q  <= 1'b1;
                  imem_addr_q <= pc_in;
                  state_q     <= StWait;
               end
            end
            StWait: begin
               if (flush_in) begin
                  if (imem_ack) begin
                     imem_req_q <= 1'b0;
                     kill_q     <= 1'b0;
                     state_q    <= StIdle;
                  end else begin
                     // Request cannot be aborted; remember to drop its data.
                     kill_q <= 1'b1;
                  end
               end else if (imem_ack) begin
                  imem_req_q <= 1'b0;
                  kill_q     <= 1'b0;
                  if (!kill_q && if_id_valid && stall_in) begin
                     buf_instr_q <= imem_rdata;
                     buf_npc_q   <= fetch_npc;
                     state_q     <= StHold;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StHold: begin
               if (flush_in) begin
                  buf_instr_q <= 32'h0000_0000;
                  buf_npc_q   <= 32'h0000_0000;
                  state_q     <= StIdle;
               end else if (!stall_in) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush_in),
      .load_i  (load_en),
      .stall_i (stall_in),
      .instr_i (load_instr),
      .npc_i   (load_npc),
      .instr_o (if_id_instr),
      .npc_o   (if_id_npc),
      .valid_o (if_id_valid)
   );

endmodule
